cms_and_pipe: RTL



---
 rtl/cms_and_pipe_pkg.sv | 30 +++
 rtl/cms_and_pipe_lane.sv | 59 +++++
 rtl/cms_and_pipe.sv | 114 +++++++++++
 3 files changed

// File: rtl/cms_and_pipe_pkg.sv
// Index helpers for the CMS masked AND gadget: ring ordering of the
// cross-domain terms and the slot-to-share mapping.
package cms_pkg;

    localparam int MAX_SHARES = 8;

    function automatic int nterms(input int n);
        return n * n;
    endfunction

    function automatic int ring_idx(input int i, input int t, input int n);
        return i * n + t;
    endfunction

    function automatic int prev_idx(input int k, input int n);
        return (k + n * n - 1) % (n * n);
    endfunction

    // Slot 0 is the own domain; the remaining slots walk the other shares upward.
    function automatic int dom_j(input int i, input int t);
        if (t == 0) begin
            return i;
        end else if (t <= i) begin
            return t - 1;
        end else begin
            return t;
        end
    endfunction

endpackage

// File: rtl/cms_and_pipe_lane.sv
// One bit lane of the CMS AND: all cross-domain products, ring resharing into
// enable-gated registers, then per-share compression of the registered terms.
module cms_and_lane
    import cms_pkg::*;
#(
    parameter int NSHARES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NSHARES-1:0]           x,
    input  logic [NSHARES-1:0]           y,
    input  logic [NSHARES*NSHARES-1:0]   z,
    output logic [NSHARES-1:0]           q
);

    localparam int NTERMS = NSHARES * NSHARES;

    logic [NTERMS-1:0] term_s;
    logic [NTERMS-1:0] term_r;
    logic [NSHARES-1:0] q_s;

    // Partial products masked with the two neighbouring ring elements.
    always_comb begin
        term_s = '0;
        for (int i = 0; i < NSHARES; i++) begin
            for (int t = 0; t < NSHARES; t++) begin
                term_s[ring_idx(i, t, NSHARES)] =
                    (x[i] & y[dom_j(i, t)])
                    ^ z[ring_idx(i, t, NSHARES)]
                    ^ z[prev_idx(ring_idx(i, t, NSHARES), NSHARES)];
            end
        end
    end

    // Resharing registers; they hold unless a new input is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            term_r <= '0;
        end else if (en) begin
            term_r <= term_s;
        end else begin
            term_r <= term_r;
        end
    end

    // Compression only ever sees registered terms.
    always_comb begin
        q_s = '0;
        for (int i = 0; i < NSHARES; i++) begin
            for (int t = 0; t < NSHARES; t++) begin
                q_s[i] = q_s[i] ^ term_r[ring_idx(i, t, NSHARES)];
            end
        end
    end

    assign q = q_s;

endmodule

// File: rtl/cms_and_pipe.sv
// Pipelined multi-lane CMS masked AND with valid/ready handshake and an
// optional output register stage.
module cms_and_pipe
    import cms_pkg::*;
#(
    parameter int NSHARES = 4,
    parameter int WIDTH   = 1,
    parameter int OUT_REG = 0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NSHARES*WIDTH-1:0]             X_i,
    input  logic [NSHARES*WIDTH-1:0]             Y_i,
    input  logic [NSHARES*NSHARES*WIDTH-1:0]     Z_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    output logic [NSHARES*WIDTH-1:0]             Q_o,
    output logic                                 valid_o,
    input  logic                                 ready_i
);

    localparam int NTERMS = nterms(NSHARES);

    logic                       accept_s;
    logic [NSHARES*WIDTH-1:0]   qc_s;

    assign accept_s = valid_i && ready_o;

    for (genvar w = 0; w < WIDTH; w++) begin : g_lane
        logic [NSHARES-1:0] xl_s;
        logic [NSHARES-1:0] yl_s;
        logic [NTERMS-1:0]  zl_s;
        logic [NSHARES-1:0] ql_s;

        for (genvar s = 0; s < NSHARES; s++) begin : g_share
            assign xl_s[s]             = X_i[s*WIDTH + w];
            assign yl_s[s]             = Y_i[s*WIDTH + w];
            assign qc_s[s*WIDTH + w]   = ql_s[s];
        end

        for (genvar k = 0; k < NTERMS; k++) begin : g_ring
            assign zl_s[k] = Z_i[k*WIDTH + w];
        end

        cms_and_lane #(.NSHARES(NSHARES)) u_lane (
            .clk (clk_i),
            .rst (rst_i),
            .en  (accept_s),
            .x   (xl_s),
            .y   (yl_s),
            .z   (zl_s),
            .q   (ql_s)
        );
    end

    if (OUT_REG == 0) begin : g_single
        logic v1_r;

        assign ready_o = !v1_r || ready_i;
        assign valid_o = v1_r;
        assign Q_o     = qc_s;

        // Output valid follows the resharing registers directly.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                v1_r <= 1'b0;
            end else if (accept_s) begin
                v1_r <= 1'b1;
            end else if (ready_i) begin
                v1_r <= 1'b0;
            end else begin
                v1_r <= v1_r;
            end
        end
    end else begin : g_double
        logic                     v1_r;
        logic                     v2_r;
        logic [NSHARES*WIDTH-1:0] q2_r;
        logic                     load2_s;

        assign load2_s = v1_r && (!v2_r || ready_i);
        assign ready_o = !v1_r || !v2_r || ready_i;
        assign valid_o = v2_r;
        assign Q_o     = q2_r;

        // Stage 1 holds the reshared terms; stage 2 holds the compressed shares.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                v1_r <= 1'b0;
                v2_r <= 1'b0;
                q2_r <= '0;
            end else begin
                if (accept_s) begin
                    v1_r <= 1'b1;
                end else if (load2_s) begin
                    v1_r <= 1'b0;
                end else begin
                    v1_r <= v1_r;
                end
                if (load2_s) begin
                    v2_r <= 1'b1;
                    q2_r <= qc_s;
                end else if (ready_i) begin
                    v2_r <= 1'b0;
                    q2_r <= q2_r;
                end else begin
                    v2_r <= v2_r;
                    q2_r <= q2_r;
                end
            end
        end
    end

endmodule
